// File: rtl/utf8_encode_if.sv
// Code-point in / UTF-8 byte out handshake bundle for utf8_encode.
// master = the environment (source and sink), slave = the encoder.
interface utf8_encode_if;
    logic [20:0] unicode;
    logic        ie;
    logic        ready;
    logic [7:0]  current_byte;
    logic        oe;
    logic        ack;

    modport master (
        output unicode, ie, ack,
        input  ready, current_byte, oe
    );

    modport slave (
        input  unicode, ie, ack,
        output ready, current_byte, oe
    );
endinterface

// File: rtl/utf8_encode.sv
// Unicode code point to UTF-8 byte-stream encoder: accepts one code point in IDLE,
// then emits its 1-4 bytes most-significant first under an oe/ack handshake.
module utf8_encode #(
    parameter bit REPLACE_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    utf8_encode_if.slave bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;
    logic [7:0]  r_bytes [4];
    logic [7:0]  r_current_byte;
    logic        r_oe;

    logic [20:0] w_cp;
    logic        w_invalid;
    logic [1:0]  w_last;
    logic [7:0]  w_bytes [4];
    logic        w_load;

    // Encode the presented code point every cycle; it is only captured on acceptance.
    always_comb begin
        w_cp       = bus.unicode;
        w_invalid  = ((w_cp >= 21'h00D800) && (w_cp <= 21'h00DFFF)) || (w_cp > 21'h10FFFF);
        w_last     = 2'd0;
        w_bytes[0] = 8'h00;
        w_bytes[1] = 8'h00;
        w_bytes[2] = 8'h00;
        w_bytes[3] = 8'h00;
        if (w_invalid) begin
            w_bytes[0] = 8'hEF;
            w_bytes[1] = 8'hBF;
            w_bytes[2] = 8'hBD;
            w_last     = 2'd2;
        end else if (w_cp < 21'h000080) begin
            w_bytes[0] = {1'b0, w_cp[6:0]};
        end else if (w_cp < 21'h000800) begin
            w_bytes[0] = {3'b110, w_cp[10:6]};
            w_bytes[1] = {2'b10, w_cp[5:0]};
            w_last     = 2'd1;
        end else if (w_cp < 21'h010000) begin
            w_bytes[0] = {4'b1110, w_cp[15:12]};
            w_bytes[1] = {2'b10, w_cp[11:6]};
            w_bytes[2] = {2'b10, w_cp[5:0]};
            w_last     = 2'd2;
        end else begin
            w_bytes[0] = {5'b11110, w_cp[20:18]};
            w_bytes[1] = {2'b10, w_cp[17:12]};
            w_bytes[2] = {2'b10, w_cp[11:6]};
            w_bytes[3] = {2'b10, w_cp[5:0]};
            w_last     = 2'd3;
        end
    end

    // Invalid input with replacement disabled is simply never loaded.
    assign w_load = bus.ie && (r_state == IDLE) && (!w_invalid || REPLACE_INVALID);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_idx          <= 2'd0;
            r_oe           <= 1'b0;
            r_current_byte <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        // NOTE: r_bytes/r_last are plain data registers with no reset;
                        // they are always written at acceptance before being read.
                        r_bytes        <= w_bytes;
                        r_last         <= w_last;
                        r_idx          <= 2'd0;
                        r_current_byte <= w_bytes[0];
                        r_oe           <= 1'b1;
                        r_state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.ack) begin
                        if (r_idx == r_last) begin
                            r_oe    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx          <= r_idx + 2'd1;
                            r_current_byte <= r_bytes[r_idx + 2'd1];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ready comes from registered state, masked only by reset.
    assign bus.ready        = (r_state == IDLE) && !reset;
    assign bus.current_byte = r_current_byte;
    assign bus.oe           = r_oe;

endmodule

// File: tb/tb_utf8_encode.sv
// Self-checking bench for utf8_encode: spec vector table, hand-written corner
// sequences, and randomized traffic checked against an arithmetic UTF-8 model.
module tb_utf8_encode;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    utf8_encode_if b1 ();
    utf8_encode_if b0 ();

    utf8_encode #(.REPLACE_INVALID(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    utf8_encode #(.REPLACE_INVALID(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [20:0] cp;
        int          n;
        logic [31:0] bytes;   // first byte in [31:24]
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UTF-8 from the definition: leading marker plus 6-bit groups by division.
    function automatic int ref_encode(input int unsigned cp_in, input bit replace,
                                      output logic [31:0] bytes);
        int unsigned cp;
        cp    = cp_in;
        bytes = 32'h0;
        if ((cp >= 32'hD800 && cp <= 32'hDFFF) || cp > 32'h10FFFF) begin
            if (!replace) return 0;
            cp = 32'hFFFD;
        end
        if (cp < 128) begin
            bytes = {8'(cp), 24'h0};
            return 1;
        end else if (cp < 2048) begin
            bytes = {8'(192 + cp / 64), 8'(128 + cp % 64), 16'h0};
            return 2;
        end else if (cp < 65536) begin
            bytes = {8'(224 + cp / 4096), 8'(128 + (cp / 64) % 64), 8'(128 + cp % 64), 8'h0};
            return 3;
        end
        bytes = {8'(240 + cp / 262144), 8'(128 + (cp / 4096) % 64),
                 8'(128 + (cp / 64) % 64), 8'(128 + cp % 64)};
        return 4;
    endfunction

    function automatic logic [20:0] rand_cp();
        case ($urandom_range(5))
            0:       return 21'($urandom_range(32'h7F, 0));
            1:       return 21'($urandom_range(32'h7FF, 32'h80));
            2:       return 21'($urandom_range(32'hFFFF, 32'h800));
            3:       return 21'($urandom_range(32'h10FFFF, 32'h10000));
            4:       return 21'($urandom_range(32'hDFFF, 32'hD800));
            default: return 21'($urandom_range(32'h1FFFFF, 32'h110000));
        endcase
    endfunction

    function automatic logic pick_ack(input int pct, input int stalls);
        return (stalls >= 20) || ($urandom_range(99) < pct);
    endfunction

    // Send one code point to dut1 and consume its bytes with random ack stalls.
    task automatic xfer(input string name, input logic [20:0] cp, input logic [31:0] exp,
                        input int n, input int ack_pct, input bit noise);
        int guard;
        int stalls;
        logic [7:0] eb;
        guard = 0;
        while (b1.ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check({name, " ready wait"}, 32'(b1.ready), 32'd1);
        b1.unicode = cp;
        b1.ie      = 1'b1;
        @(posedge clk); #1;
        b1.ie      = 1'b0;
        b1.unicode = 21'($urandom);
        check({name, " ready low after accept"}, 32'(b1.ready), 32'd0);
        for (int k = 0; k < n; k++) begin
            eb     = exp[31 - 8 * k -: 8];
            stalls = 0;
            b1.ack = pick_ack(ack_pct, stalls);
            b1.ie  = noise ? 1'($urandom) : 1'b0;
            while (!b1.ack) begin
                check({name, " hold"}, 32'({b1.oe, b1.current_byte}), 32'({1'b1, eb}));
                @(posedge clk); #1;
                stalls++;
                b1.ack = pick_ack(ack_pct, stalls);
                b1.ie  = noise ? 1'($urandom) : 1'b0;
            end
            check({name, " byte"}, 32'({b1.oe, b1.current_byte}), 32'({1'b1, eb}));
            @(posedge clk); #1;
        end
        b1.ie = 1'b0;
        check({name, " oe low at end"}, 32'(b1.oe), 32'd0);
        check({name, " ready at end"}, 32'(b1.ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e;
        logic [20:0] cp;
        int n;

        vecs[0]  = '{21'h000041, 1, 32'h41000000};
        vecs[1]  = '{21'h00007F, 1, 32'h7F000000};
        vecs[2]  = '{21'h000080, 2, 32'hC2800000};
        vecs[3]  = '{21'h0000E9, 2, 32'hC3A90000};
        vecs[4]  = '{21'h0007FF, 2, 32'hDFBF0000};
        vecs[5]  = '{21'h000800, 3, 32'hE0A08000};
        vecs[6]  = '{21'h0020AC, 3, 32'hE282AC00};
        vecs[7]  = '{21'h00D7FF, 3, 32'hED9FBF00};
        vecs[8]  = '{21'h00E000, 3, 32'hEE808000};
        vecs[9]  = '{21'h00FFFF, 3, 32'hEFBFBF00};
        vecs[10] = '{21'h010000, 4, 32'hF0908080};
        vecs[11] = '{21'h01F600, 4, 32'hF09F9880};
        vecs[12] = '{21'h10FFFF, 4, 32'hF48FBFBF};
        vecs[13] = '{21'h00D800, 3, 32'hEFBFBD00};
        vecs[14] = '{21'h00DFFF, 3, 32'hEFBFBD00};
        vecs[15] = '{21'h110000, 3, 32'hEFBFBD00};
        vecs[16] = '{21'h1FFFFF, 3, 32'hEFBFBD00};

        reset = 1'b1;
        b1.ie = 1'b0; b1.ack = 1'b0; b1.unicode = '0;
        b0.ie = 1'b0; b0.ack = 1'b0; b0.unicode = '0;
        @(posedge clk); #1;
        check("ready low in reset", 32'(b1.ready), 32'd0);
        @(posedge clk); #1;
        check("oe after reset", 32'(b1.oe), 32'd0);
        check("byte after reset", 32'(b1.current_byte), 32'd0);
        check("oe after reset r0", 32'(b0.oe), 32'd0);
        reset = 1'b0;
        #1;
        check("ready after reset", 32'(b1.ready), 32'd1);

        // Spec vectors, continuous ack; odd entries also pulse ie while busy.
        foreach (vecs[i])
            xfer($sformatf("vec%0d", i), vecs[i].cp, vecs[i].bytes, vecs[i].n, 100, i[0]);

        // Lead byte held through three stalled cycles.
        b1.unicode = 21'h0020AC; b1.ie = 1'b1; b1.ack = 1'b0;
        @(posedge clk); #1;
        b1.ie = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall E2", 32'({b1.oe, b1.current_byte}), 32'h1E2);
            @(posedge clk); #1;
        end
        b1.ack = 1'b1;
        check("stall E2 4th", 32'({b1.oe, b1.current_byte}), 32'h1E2);
        @(posedge clk); #1;
        check("stall 82", 32'({b1.oe, b1.current_byte}), 32'h182);
        @(posedge clk); #1;
        check("stall AC", 32'({b1.oe, b1.current_byte}), 32'h1AC);
        @(posedge clk); #1;
        check("stall end oe", 32'(b1.oe), 32'd0);
        check("stall end ready", 32'(b1.ready), 32'd1);

        // Reset in the middle of a 4-byte character.
        b1.unicode = 21'h01F600; b1.ie = 1'b1; b1.ack = 1'b1;
        @(posedge clk); #1;
        b1.ie = 1'b0;
        check("abort F0", 32'({b1.oe, b1.current_byte}), 32'h1F0);
        @(posedge clk); #1;
        check("abort 9F shown", 32'({b1.oe, b1.current_byte}), 32'h19F);
        b1.ack = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        check("abort oe cleared", 32'(b1.oe), 32'd0);
        check("abort ready in reset", 32'(b1.ready), 32'd0);
        reset = 1'b0;
        #1;
        check("abort ready after reset", 32'(b1.ready), 32'd1);
        b1.ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort no more bytes", 32'(b1.oe), 32'd0);
        end

        // Randomized traffic on the replacing encoder.
        for (int i = 0; i < 150; i++) begin
            cp = rand_cp();
            n  = ref_encode(32'(cp), 1'b1, e);
            xfer($sformatf("rnd%0d cp=%0h", i, cp), cp, e, n, $urandom_range(100, 30), 1'($urandom));
        end

        // Dropping encoder: explicit invalids, then random traffic.
        b0.ack = 1'b1;
        for (int i = 0; i < 44; i++) begin
            cp = (i == 0) ? 21'h00D800 : (i == 1) ? 21'h110000 : (i == 2) ? 21'h000041 : rand_cp();
            n  = ref_encode(32'(cp), 1'b0, e);
            b0.unicode = cp;
            b0.ie      = 1'b1;
            @(posedge clk); #1;
            b0.ie      = 1'b0;
            b0.unicode = 21'($urandom);
            for (int k = 0; k < n; k++) begin
                check($sformatf("drop%0d byte%0d", i, k), 32'({b0.oe, b0.current_byte}),
                      32'({1'b1, e[31 - 8 * k -: 8]}));
                @(posedge clk); #1;
            end
            check($sformatf("drop%0d oe", i), 32'(b0.oe), 32'd0);
            check($sformatf("drop%0d ready", i), 32'(b0.ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/utf8_encode.md
UTF8_ENCODE -- requirements
Module: utf8_encode

Interface
REQ-001 SHALL provide parameter: REPLACE_INVALID, default 1, 1 = invalid code point emitted as U+FFFD, 0 = invalid code point discarded.
REQ-002 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: unicode  input  21  code point to encode, sampled when accepted.
REQ-005 SHALL have port: ie  input  1  code point valid strobe.
REQ-006 SHALL have port: ready  output  1  encoder can accept a code point this cycle.
REQ-007 SHALL have port: current_byte  output  8  encoded UTF-8 byte.
REQ-008 SHALL have port: oe  output  1  current_byte valid.
REQ-009 SHALL have port: ack  input  1  downstream consumes current_byte when oe && ack.

Function
REQ-010 SHALL be a two-state FSM, IDLE and EMIT, plus 2-bit byte index and 2-bit last-index registers.
REQ-011 SHALL drive ready = 1 in IDLE and 0 in EMIT, decoded from registered state only; no combinational path from ack or ie.
REQ-012 SHALL accept a code point on a rising edge where ie && ready; ie while ready = 0 SHALL be ignored, with no state change.
REQ-013 SHALL encode U+0000..U+007F as 1 byte: 0xxxxxxx.
REQ-014 SHALL encode U+0080..U+07FF as 2 bytes: 110xxxxx 10xxxxxx.
REQ-015 SHALL encode U+0800..U+FFFF, excluding U+D800..U+DFFF, as 3 bytes: 1110xxxx 10xxxxxx 10xxxxxx.
REQ-016 SHALL encode U+10000..U+10FFFF as 4 bytes: 11110xxx 10xxxxxx 10xxxxxx 10xxxxxx.
REQ-017 SHALL treat surrogates U+D800..U+DFFF and values > U+10FFFF as invalid.
REQ-018 With REPLACE_INVALID=1, an invalid input SHALL emit EF BF BD.
REQ-019 With REPLACE_INVALID=0, an invalid input SHALL be dropped: no oe, FSM stays in IDLE, ready stays 1.
REQ-020 SHALL precompute all bytes into internal registers at acceptance; unicode MAY change after the acceptance edge.
REQ-021 Latency: a code point accepted at edge N SHALL present its first byte with oe = 1 after edge N (visible in cycle N+1).
REQ-022 SHALL emit bytes most-significant first, one per edge where oe && ack.
REQ-023 SHALL hold current_byte and oe stable while oe && !ack, for any number of cycles.
REQ-024 On oe && ack for the last byte, SHALL deassert oe, return to IDLE, and assert ready in the next cycle.
REQ-025 A 1-byte character with ack continuously high SHALL occupy exactly 2 cycles from acceptance to ready.
REQ-026 An n-byte character with ack continuously high SHALL assert oe for exactly n consecutive cycles.
REQ-027 oe SHALL be 0 whenever the FSM is in IDLE; current_byte SHALL be don't-care when oe = 0.

Reset
REQ-028 While reset = 1 at an edge: oe <= 0, current_byte <= 8'h00, state <= IDLE, byte index <= 0.
REQ-029 SHALL hold ready at 0 during any cycle in which reset is asserted.
REQ-030 Reset mid-sequence SHALL abort the character: no further bytes of it are emitted, and ready = 1 in the first cycle after reset deasserts.
REQ-031 reset SHALL take priority over ie and ack at the same edge.

Verification
REQ-032 unicode=0x41, ie pulse, ack=1 -> one cycle oe=1, current_byte=41; ready=1 two cycles after acceptance.
REQ-033 U+00E9 then U+20AC, ack=1 -> C3 A9, ready, then E2 82 AC; ie pulses while ready=0 produce no extra bytes.
REQ-034 U+20AC with ack=0 for 3 cycles after the first oe -> E2 held 4 cycles, then 82, AC.
REQ-035 U+1F600 and U+10FFFF -> F0 9F 98 80 and F4 8F BF BF.
REQ-036 U+D800 and U+110000 -> EF BF BD each with REPLACE_INVALID=1; no oe and ready stays 1 with REPLACE_INVALID=0.
REQ-037 U+1F600 with reset asserted one cycle after the first byte F0 is acked -> oe=0 after the reset edge, no 9F emitted, ready=1 after reset deasserts.
